// File: rtl/ultrasonic_sequencer.sv
// Ultrasonic ranging sequencer: trigger pulse, echo-rise wait, echo-width timing, repetition holdoff.
// Optional macro ULTRASONIC_ECHO_SYNC_EN puts a 2-flop synchronizer in front of the echo logic.
module ultrasonic_sequencer #(
    parameter int WIDTH         = 32,
    parameter int TRIG_CYCLES   = 500,
    parameter int RISE_TIMEOUT  = 50000,
    parameter int ECHO_MAX      = 1900000,
    parameter int PERIOD_CYCLES = 3000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             echo_in,
    output logic             trigger_out,
    output logic [WIDTH-1:0] width,
    output logic             width_valid,
    output logic             timeout,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] TRIG_LAST   = WIDTH'(TRIG_CYCLES - 1);
    localparam logic [WIDTH-1:0] RISE_LAST   = WIDTH'(RISE_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ECHO_LIMIT  = WIDTH'(ECHO_MAX);
    localparam logic [WIDTH-1:0] PERIOD_LAST = WIDTH'(PERIOD_CYCLES - 1);
    localparam logic [WIDTH-1:0] PERIOD_SAT  = WIDTH'(PERIOD_CYCLES);
    localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_trig_cnt;
    logic [WIDTH-1:0] r_wait_cnt;
    logic [WIDTH-1:0] r_width_cnt;
    logic [WIDTH-1:0] r_period_cnt;
    logic             r_echo_q;
    logic             w_echo;
    logic             w_rise;
    logic             w_fire;
    logic [WIDTH-1:0] w_fire_width;
    logic             w_fire_timeout;

`ifdef ULTRASONIC_ECHO_SYNC_EN
    logic [1:0] r_echo_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_echo_sync <= 2'b00;
        end else begin
            r_echo_sync <= {r_echo_sync[0], echo_in};
        end
    end

    assign w_echo = r_echo_sync[1];
`else
    assign w_echo = echo_in;
`endif

    // A level that is already high when WAIT_RISE starts is not a rise.
    assign w_rise = w_echo & ~r_echo_q;

    always_comb begin
        w_state_next   = r_state;
        w_fire         = 1'b0;
        w_fire_width   = '0;
        w_fire_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_next = TRIG;
            end
            TRIG: begin
                if (r_trig_cnt == TRIG_LAST) w_state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    w_state_next = MEASURE;
                end else if (r_wait_cnt == RISE_LAST) begin
                    w_fire         = 1'b1;
                    w_fire_timeout = 1'b1;
                    w_state_next   = HOLDOFF;
                end
            end
            MEASURE: begin
                if (!w_echo) begin
                    w_fire       = 1'b1;
                    w_fire_width = r_width_cnt;
                    w_state_next = HOLDOFF;
                end else if (r_width_cnt >= ECHO_LIMIT) begin
                    w_fire         = 1'b1;
                    w_fire_width   = ECHO_LIMIT;
                    w_fire_timeout = 1'b1;
                    w_state_next   = HOLDOFF;
                end
            end
            HOLDOFF: begin
                // Leaving on this edge makes the next trigger rise land exactly one period after the last.
                if (r_period_cnt >= PERIOD_LAST) w_state_next = enable ? TRIG : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_trig_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_width_cnt  <= '0;
            r_period_cnt <= '0;
            r_echo_q     <= 1'b0;
            width        <= '0;
            width_valid  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_echo_q <= w_echo;

            r_trig_cnt <= (r_state == TRIG && w_state_next == TRIG) ? r_trig_cnt + ONE : '0;
            r_wait_cnt <= (r_state == WAIT_RISE && w_state_next == WAIT_RISE) ? r_wait_cnt + ONE : '0;

            if (r_state == WAIT_RISE && w_state_next == MEASURE) begin
                r_width_cnt <= ONE;
            end else if (r_state == MEASURE && w_state_next == MEASURE) begin
                r_width_cnt <= r_width_cnt + ONE;
            end else begin
                r_width_cnt <= '0;
            end

            if (w_state_next == TRIG && r_state != TRIG) begin
                r_period_cnt <= '0;
            end else if (r_state != IDLE && r_period_cnt < PERIOD_SAT) begin
                r_period_cnt <= r_period_cnt + ONE;
            end

            width_valid <= w_fire;
            if (w_fire) begin
                width   <= w_fire_width;
                timeout <= w_fire_timeout;
            end
        end
    end

    assign trigger_out = (r_state == TRIG);
    assign busy        = (r_state != IDLE);
    assign dbg_state   = r_state;

endmodule
